// File: rtl/ir_cmd_ctrl_pkg.sv
// Shared types and constants for the IR command controller.
package ir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_HOLD  = 2'd2
    } ir_state_e;

    // NEC frame layout: addr, ~addr, cmd, ~cmd (MSB first)
    localparam int FRM_ADDR_LSB  = 24;
    localparam int FRM_NADDR_LSB = 16;
    localparam int FRM_CMD_LSB   = 8;
    localparam int FRM_NCMD_LSB  = 0;

    localparam int ENTRY_W   = 17;
    localparam int BUF_DEPTH = 4;

    typedef struct packed {
        logic       rpt;
        logic [7:0] addr;
        logic [7:0] cmd;
    } ir_entry_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFF : v + 8'd1;
    endfunction

endpackage

// File: rtl/ir_cmd_ctrl_if.sv
// Receiver-side strobes and consumer-side handshake of the command controller.
interface ir_cmd_ctrl_if;
    logic [31:0] i_frame_data;
    logic        i_frame_vld;
    logic        i_rpt_vld;
    logic [7:0]  o_cmd;
    logic [7:0]  o_addr;
    logic        o_cmd_rpt;
    logic        o_cmd_vld;
    logic        i_cmd_rdy;
    logic [7:0]  o_err_cnt;
    logic        o_ovf;
    logic        o_hold;

    modport slave (
        input  i_frame_data, i_frame_vld, i_rpt_vld, i_cmd_rdy,
        output o_cmd, o_addr, o_cmd_rpt, o_cmd_vld, o_err_cnt, o_ovf, o_hold
    );

    modport master (
        output i_frame_data, i_frame_vld, i_rpt_vld, i_cmd_rdy,
        input  o_cmd, o_addr, o_cmd_rpt, o_cmd_vld, o_err_cnt, o_ovf, o_hold
    );
endinterface

// File: rtl/ir_cmd_ctrl_fifo.sv
// 4-deep command buffer; a push into a full buffer is accepted when the
// head is popped in the same cycle, otherwise it is dropped and flagged.
module ir_cmd_fifo
    import ir_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  ir_entry_t push_data,
    input  logic      pop,
    output ir_entry_t head,
    output logic      empty,
    output logic      full,
    output logic      drop,
    output logic [2:0] count
);

    ir_entry_t  mem [BUF_DEPTH];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic       do_push;
    logic       do_pop;

    assign empty   = (count == 3'd0);
    assign full    = (count == 3'(BUF_DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && !do_push;
    assign head    = empty ? '0 : mem[rd_ptr];

    // storage, pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 2'd1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            count <= count + 3'(do_push) - 3'(do_pop);
        end
    end

endmodule

// File: rtl/ir_cmd_ctrl.sv
// IR command controller: validates NEC frames, runs repeat-hold with
// typematic delay and timeout, and queues commands for the consumer.
module ir_cmd_ctrl
    import ir_pkg::*;
#(
    parameter int         TICK_DIV      = 50000,
    parameter int         RPT_TIMEOUT   = 120,
    parameter int         RPT_DELAY     = 3,
    parameter int         ADDR_MATCH_EN = 0,
    parameter logic [7:0] DEV_ADDR      = 8'h00,
    parameter int         EXT_ADDR      = 0
) (
    input logic          clk,
    input logic          rst,
    ir_cmd_ctrl_if.slave bus
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    ir_state_e   state;
    logic [31:0] frame_q;
    logic [7:0]  last_addr;
    logic [7:0]  last_cmd;
    logic [15:0] timer;
    logic [7:0]  rpt_cnt;
    logic [7:0]  err_cnt;
    logic        ovf;
    logic [PRE_W-1:0] presc;
    logic        tick;

    logic [7:0]  f_addr, f_naddr, f_cmd, f_ncmd;
    logic        frame_ok;
    logic [7:0]  rpt_cnt_inc;
    logic        rpt_emit;

    logic        push;
    ir_entry_t   push_data;
    ir_entry_t   head;
    logic        empty, full, drop;
    logic [2:0]  count;

    assign f_addr  = frame_q[FRM_ADDR_LSB  +: 8];
    assign f_naddr = frame_q[FRM_NADDR_LSB +: 8];
    assign f_cmd   = frame_q[FRM_CMD_LSB   +: 8];
    assign f_ncmd  = frame_q[FRM_NCMD_LSB  +: 8];

    assign frame_ok = (f_cmd == ~f_ncmd)
                   && ((EXT_ADDR != 0) || (f_addr == ~f_naddr))
                   && ((ADDR_MATCH_EN == 0) || (f_addr == DEV_ADDR));

    assign rpt_cnt_inc = sat_inc8(rpt_cnt);
    assign rpt_emit    = 32'(rpt_cnt_inc) > RPT_DELAY;
    assign tick        = (presc == PRE_W'(TICK_DIV - 1));

    // free-running 1 ms timebase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // buffer push source: fresh frame out of CHECK, or auto-repeat in HOLD
    // (a frame strobe in the same cycle pre-empts the repeat)
    always_comb begin
        push      = 1'b0;
        push_data = '0;
        if (state == ST_CHECK && frame_ok) begin
            push      = 1'b1;
            push_data = '{rpt: 1'b0, addr: f_addr, cmd: f_cmd};
        end else if (state == ST_HOLD && bus.i_rpt_vld && !bus.i_frame_vld && rpt_emit) begin
            push      = 1'b1;
            push_data = '{rpt: 1'b1, addr: last_addr, cmd: last_cmd};
        end
    end

    // command sequencing FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            frame_q   <= '0;
            last_addr <= '0;
            last_cmd  <= '0;
            timer     <= '0;
            rpt_cnt   <= '0;
            err_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.i_frame_vld) begin
                        frame_q <= bus.i_frame_data;
                        state   <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (frame_ok) begin
                        last_addr <= f_addr;
                        last_cmd  <= f_cmd;
                        timer     <= '0;
                        rpt_cnt   <= '0;
                        state     <= ST_HOLD;
                    end else begin
                        err_cnt <= sat_inc8(err_cnt);
                        state   <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (bus.i_frame_vld) begin
                        frame_q <= bus.i_frame_data;
                        state   <= ST_CHECK;
                    end else if (bus.i_rpt_vld) begin
                        timer   <= '0;
                        rpt_cnt <= rpt_cnt_inc;
                    end else if (timer == 16'(RPT_TIMEOUT)) begin
                        state <= ST_IDLE;
                    end else if (tick) begin
                        timer <= timer + 16'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // sticky overflow flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end
    end

    ir_cmd_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (bus.i_cmd_rdy),
        .head      (head),
        .empty     (empty),
        .full      (full),
        .drop      (drop),
        .count     (count)
    );

    assign bus.o_cmd     = head.cmd;
    assign bus.o_addr    = head.addr;
    assign bus.o_cmd_rpt = head.rpt;
    assign bus.o_cmd_vld = !empty;
    assign bus.o_err_cnt = err_cnt;
    assign bus.o_ovf     = ovf;
    assign bus.o_hold    = (state == ST_HOLD);

endmodule

// File: tb/tb_ir_cmd_ctrl.sv
// Directed plus randomized bench for ir_cmd_ctrl.
module tb_ir_cmd_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ir_cmd_ctrl_if bus ();
    ir_cmd_ctrl_if bus_f ();

    ir_cmd_ctrl #(.TICK_DIV(10)) dut (.clk(clk), .rst(rst), .bus(bus));
    ir_cmd_ctrl #(.TICK_DIV(10), .ADDR_MATCH_EN(1), .DEV_ADDR(8'h04)) dut_f (.clk(clk), .rst(rst), .bus(bus_f));

    int tests = 0;
    int fails = 0;

    logic mon_en  = 1'b0;
    logic rdy_dir = 1'b0;
    logic rdy_rnd = 1'b0;
    assign bus.i_cmd_rdy = mon_en ? rdy_rnd : rdy_dir;

    // reference model state for the random phase
    logic [16:0] exp_q[$];
    logic        m_hold;
    logic [7:0]  m_addr, m_cmd;
    int          m_rpt;
    int          m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [7:0] a, input logic [7:0] c);
        return {a, ~a, c, ~c};
    endfunction

    task automatic tick_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [31:0] d);
        @(negedge clk);
        bus.i_frame_data = d;
        bus.i_frame_vld  = 1'b1;
        @(negedge clk);
        bus.i_frame_vld  = 1'b0;
    endtask

    task automatic send_rpt();
        @(negedge clk);
        bus.i_rpt_vld = 1'b1;
        @(negedge clk);
        bus.i_rpt_vld = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic rpt, input logic [7:0] a, input logic [7:0] c);
        check({tag, "_vld"}, 32'(bus.o_cmd_vld), 32'd1);
        check({tag, "_entry"}, 32'({bus.o_cmd_rpt, bus.o_addr, bus.o_cmd}), 32'({rpt, a, c}));
        rdy_dir = 1'b1;
        @(negedge clk);
        rdy_dir = 1'b0;
    endtask

    // random-phase consumer: random ready, compares each popped entry with the model
    always @(negedge clk) begin
        if (mon_en) begin
            rdy_rnd = ($urandom_range(0, 3) != 0);
            if (bus.o_cmd_vld && rdy_rnd) begin
                check("rand_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    check("rand_entry", 32'({bus.o_cmd_rpt, bus.o_addr, bus.o_cmd}), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        logic [31:0] d;
        logic [7:0]  ra, rc;
        int          kind;

        bus.i_frame_data   = '0;
        bus.i_frame_vld    = 1'b0;
        bus.i_rpt_vld      = 1'b0;
        bus_f.i_frame_data = '0;
        bus_f.i_frame_vld  = 1'b0;
        bus_f.i_rpt_vld    = 1'b0;
        bus_f.i_cmd_rdy    = 1'b0;
        rst = 1'b1;
        tick_n(3);
        check("rst_vld",  32'(bus.o_cmd_vld), 32'd0);
        check("rst_cmd",  32'({bus.o_cmd_rpt, bus.o_addr, bus.o_cmd}), 32'd0);
        check("rst_err",  32'(bus.o_err_cnt), 32'd0);
        check("rst_ovf",  32'(bus.o_ovf), 32'd0);
        check("rst_hold", 32'(bus.o_hold), 32'd0);
        rst = 1'b0;
        tick_n(2);

        // valid frame and its latency
        send_frame(32'h00FF_16E9);
        check("lat_n1_vld", 32'(bus.o_cmd_vld), 32'd0);
        @(negedge clk);
        check("lat_n2_hold", 32'(bus.o_hold), 32'd1);
        pop_check("valid", 1'b0, 8'h00, 8'h16);
        check("valid_empty", 32'(bus.o_cmd_vld), 32'd0);

        // bad command complement
        send_frame(32'h00FF_16E8);
        tick_n(2);
        check("bad_err",  32'(bus.o_err_cnt), 32'd1);
        check("bad_vld",  32'(bus.o_cmd_vld), 32'd0);
        check("bad_hold", 32'(bus.o_hold), 32'd0);

        // repeat sequence: 5 repeats 100 ms apart -> 1 normal + 2 auto-repeat
        send_frame(32'h00FF_16E9);
        repeat (5) begin
            tick_n(998);
            send_rpt();
        end
        tick_n(1);
        pop_check("rpt_e0", 1'b0, 8'h00, 8'h16);
        pop_check("rpt_e1", 1'b1, 8'h00, 8'h16);
        pop_check("rpt_e2", 1'b1, 8'h00, 8'h16);
        check("rpt_count", 32'(bus.o_cmd_vld), 32'd0);
        tick_n(1140);
        check("rpt_hold_before_to", 32'(bus.o_hold), 32'd1);
        tick_n(70);
        check("rpt_hold_after_to", 32'(bus.o_hold), 32'd0);
        send_rpt();
        tick_n(2);
        check("rpt_idle_ignored", 32'(bus.o_cmd_vld), 32'd0);

        // error counter saturation (1 already counted)
        repeat (300) begin
            send_frame(32'h00FF_16E8);
            tick_n(1);
        end
        check("err_sat", 32'(bus.o_err_cnt), 32'd255);

        // address filter
        @(negedge clk);
        bus_f.i_frame_data = 32'h00FF_16E9;
        bus_f.i_frame_vld  = 1'b1;
        @(negedge clk);
        bus_f.i_frame_vld  = 1'b0;
        tick_n(2);
        check("filt_rej_err", 32'(bus_f.o_err_cnt), 32'd1);
        check("filt_rej_vld", 32'(bus_f.o_cmd_vld), 32'd0);
        bus_f.i_frame_data = 32'h04FB_16E9;
        bus_f.i_frame_vld  = 1'b1;
        @(negedge clk);
        bus_f.i_frame_vld  = 1'b0;
        tick_n(1);
        check("filt_acc_vld", 32'(bus_f.o_cmd_vld), 32'd1);
        check("filt_acc_entry", 32'({bus_f.o_cmd_rpt, bus_f.o_addr, bus_f.o_cmd}), 32'({1'b0, 8'h04, 8'h16}));
        check("filt_acc_err", 32'(bus_f.o_err_cnt), 32'd1);

        // fill to full, then push with a simultaneous pop
        for (int k = 0; k < 4; k++) begin
            send_frame(mk(8'h10, 8'h20 + 8'(k)));
            tick_n(1);
        end
        check("full_ovf0", 32'(bus.o_ovf), 32'd0);
        @(negedge clk);
        bus.i_frame_data = mk(8'h10, 8'h24);
        bus.i_frame_vld  = 1'b1;
        @(negedge clk);
        bus.i_frame_vld  = 1'b0;
        rdy_dir          = 1'b1;
        @(negedge clk);
        rdy_dir          = 1'b0;
        check("simul_ovf0", 32'(bus.o_ovf), 32'd0);
        for (int k = 1; k < 5; k++) begin
            pop_check("simul_drain", 1'b0, 8'h10, 8'h20 + 8'(k));
        end
        check("simul_empty", 32'(bus.o_cmd_vld), 32'd0);

        // backpressure overflow
        for (int k = 0; k < 6; k++) begin
            send_frame(mk(8'h11, 8'h30 + 8'(k)));
            tick_n(1);
        end
        check("bp_ovf", 32'(bus.o_ovf), 32'd1);
        for (int k = 0; k < 4; k++) begin
            pop_check("bp_drain", 1'b0, 8'h11, 8'h30 + 8'(k));
        end
        check("bp_empty", 32'(bus.o_cmd_vld), 32'd0);

        // frame and repeat together: the repeat must not count or emit
        repeat (3) begin
            send_rpt();
            tick_n(1);
        end
        check("swallow_vld", 32'(bus.o_cmd_vld), 32'd0);
        @(negedge clk);
        bus.i_frame_data = mk(8'h12, 8'h55);
        bus.i_frame_vld  = 1'b1;
        bus.i_rpt_vld    = 1'b1;
        @(negedge clk);
        bus.i_frame_vld  = 1'b0;
        bus.i_rpt_vld    = 1'b0;
        @(negedge clk);
        pop_check("coll", 1'b0, 8'h12, 8'h55);
        tick_n(2);
        check("coll_only_one", 32'(bus.o_cmd_vld), 32'd0);

        // asynchronous reset in HOLD with 3 entries buffered
        for (int k = 0; k < 3; k++) begin
            send_frame(mk(8'h13, 8'h60 + 8'(k)));
            tick_n(1);
        end
        check("pre_rst_hold", 32'(bus.o_hold), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_vld",  32'(bus.o_cmd_vld), 32'd0);
        check("arst_hold", 32'(bus.o_hold), 32'd0);
        check("arst_err",  32'(bus.o_err_cnt), 32'd0);
        check("arst_ovf",  32'(bus.o_ovf), 32'd0);
        tick_n(2);
        rst = 1'b0;
        tick_n(2);

        // randomized traffic against the reference model
        m_hold = 1'b0;
        m_rpt  = 0;
        m_err  = 0;
        m_addr = '0;
        m_cmd  = '0;
        mon_en = 1'b1;
        for (int i = 0; i < 80; i++) begin
            kind = int'($urandom_range(0, 9));
            if (kind < 5) begin
                ra = 8'($urandom);
                rc = 8'($urandom);
                d  = mk(ra, rc);
                if (kind == 0) d[0]  = ~d[0];
                if (kind == 1) d[16] = ~d[16];
                if (d[15:8] == ~d[7:0] && d[31:24] == ~d[23:16]) begin
                    exp_q.push_back({1'b0, ra, rc});
                    m_hold = 1'b1;
                    m_addr = ra;
                    m_cmd  = rc;
                    m_rpt  = 0;
                end else begin
                    m_hold = 1'b0;
                    m_err  = (m_err < 255) ? m_err + 1 : 255;
                end
                send_frame(d);
            end else begin
                if (m_hold) begin
                    m_rpt = (m_rpt < 255) ? m_rpt + 1 : 255;
                    if (m_rpt > 3) exp_q.push_back({1'b1, m_addr, m_cmd});
                end
                send_rpt();
            end
            tick_n(int'($urandom_range(2, 15)));
        end
        tick_n(30);
        mon_en = 1'b0;
        tick_n(1);
        check("rand_all_drained", 32'(exp_q.size()), 32'd0);
        check("rand_vld_end", 32'(bus.o_cmd_vld), 32'd0);
        check("rand_err", 32'(bus.o_err_cnt), 32'(m_err));
        check("rand_ovf", 32'(bus.o_ovf), 32'd0);
        check("rand_hold", 32'(bus.o_hold), 32'(m_hold));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
